// File: rtl/dec_timer.sv
// Loadable down-counter timer: counts a loaded value down to zero on enabled
// cycles, pulses done at terminal count, then stops or reloads.
module dec_timer #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 ld,
    input  logic [DATAWIDTH-1:0] ld_val,
    input  logic                 en,
    input  logic                 auto_rl,
    output logic [DATAWIDTH-1:0] q,
    output logic                 busy,
    output logic                 done,
    output logic                 o_dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [DATAWIDTH-1:0] r_q;
    logic [DATAWIDTH-1:0] r_rl_val;
    logic                 r_busy;
    logic                 r_done;

    state_t               w_state_nxt;
    logic [DATAWIDTH-1:0] w_q_nxt;
    logic [DATAWIDTH-1:0] w_rl_val_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_ld_zero;
    logic                 w_terminal;

    assign w_ld_zero  = (ld_val == '0);
    // In RUN the count is always >= 1, so q==1 marks the terminal edge.
    assign w_terminal = (r_q == {{(DATAWIDTH-1){1'b0}}, 1'b1});

    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_rl_val_nxt = r_rl_val;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        if (ld) begin
            w_q_nxt      = ld_val;
            w_rl_val_nxt = ld_val;
            if (w_ld_zero) begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = RUN;
                w_busy_nxt  = 1'b1;
            end
        end else if (r_state == RUN && en) begin
            if (w_terminal) begin
                w_done_nxt = 1'b1;
                if (auto_rl) begin
                    w_q_nxt = r_rl_val;
                end else begin
                    w_q_nxt     = '0;
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end else begin
                w_q_nxt = r_q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_rl_val <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_rl_val <= w_rl_val_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign q           = r_q;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dec_timer.sv
// Directed bench for dec_timer: a vector table of single-edge steps plus
// hand-written multi-cycle sequences for counting, gaps, reload and wrap.
module tb_dec_timer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       ld = 1'b0;
    logic [7:0] ld_val = 8'd0;
    logic       en = 1'b0;
    logic       auto_rl = 1'b0;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] ld_val;
        logic       en;
        logic       auto_rl;
        logic [7:0] exp_q;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    dec_timer #(.DATAWIDTH(8)) dut (
        .Clk(Clk), .Rst(Rst), .ld(ld), .ld_val(ld_val), .en(en),
        .auto_rl(auto_rl), .q(q), .busy(busy), .done(done),
        .o_dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic rst, input logic l, input logic [7:0] v,
                                input logic e, input logic a, input logic [7:0] eq,
                                input logic eb, input logic ed);
        vec_t t;
        t.rst = rst; t.ld = l; t.ld_val = v; t.en = e; t.auto_rl = a;
        t.exp_q = eq; t.exp_busy = eb; t.exp_done = ed;
        return t;
    endfunction

    // Drive inputs, take one rising edge, sample 1ns later.
    task automatic step(input logic rst, input logic l, input logic [7:0] v,
                        input logic e, input logic a);
        Rst = rst; ld = l; ld_val = v; en = e; auto_rl = a;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] eq,
                         input logic eb, input logic ed);
        checks++;
        if (q !== eq || busy !== eb || done !== ed) begin
            errors++;
            $display("FAIL %s: got q=%0d busy=%b done=%b, expected q=%0d busy=%b done=%b",
                     name, q, busy, done, eq, eb, ed);
        end
    endtask

    initial begin
        // rst ld val en arl | q busy done
        vecs.push_back(mk(1, 1, 8'd10, 0, 0, 8'd0, 0, 0));
        vecs.push_back(mk(1, 1, 8'd10, 0, 0, 8'd0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,  1, 1, 8'd0, 0, 0));
        // auto-reload N=3, then clear auto_rl before terminal
        vecs.push_back(mk(0, 1, 8'd3,  1, 1, 8'd3, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0,  1, 1, 8'd2, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0,  1, 1, 8'd1, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0,  1, 1, 8'd3, 1, 1));
        vecs.push_back(mk(0, 0, 8'd0,  1, 1, 8'd2, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0,  1, 1, 8'd1, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0,  1, 0, 8'd0, 0, 1));
        vecs.push_back(mk(0, 0, 8'd0,  1, 1, 8'd0, 0, 0));
        // zero load: immediate done, back-to-back allowed
        vecs.push_back(mk(0, 1, 8'd0,  0, 0, 8'd0, 0, 1));
        vecs.push_back(mk(0, 1, 8'd0,  1, 0, 8'd0, 0, 1));
        vecs.push_back(mk(0, 0, 8'd0,  1, 0, 8'd0, 0, 0));
        // reset mid-count: no done pulse
        vecs.push_back(mk(0, 1, 8'd9,  0, 0, 8'd9, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0,  1, 0, 8'd8, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0,  1, 0, 8'd7, 1, 0));
        vecs.push_back(mk(1, 0, 8'd0,  1, 0, 8'd0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0,  1, 0, 8'd0, 0, 0));
        // load wins on terminal edge
        vecs.push_back(mk(0, 1, 8'd2,  1, 0, 8'd2, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0,  1, 0, 8'd1, 1, 0));
        vecs.push_back(mk(0, 1, 8'd4,  1, 0, 8'd4, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0,  1, 0, 8'd3, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0,  0, 0, 8'd3, 1, 0));
        vecs.push_back(mk(0, 1, 8'd1,  0, 0, 8'd1, 1, 0));
        vecs.push_back(mk(0, 1, 8'd0,  1, 0, 8'd0, 0, 1));
        vecs.push_back(mk(0, 0, 8'd0,  1, 0, 8'd0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ld, vecs[i].ld_val, vecs[i].en, vecs[i].auto_rl);
            check($sformatf("vec[%0d]", i), vecs[i].exp_q, vecs[i].exp_busy, vecs[i].exp_done);
        end

        // Basic count N=10.
        step(0, 1, 8'd10, 1, 0);
        check("basic_load", 8'd10, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 8'd0, 1, 0);
            check($sformatf("basic_k%0d", k), 8'(10 - k), (k < 10), (k == 10));
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 8'd0, 1, 0);
            check("basic_after", 8'd0, 0, 0);
        end

        // Enable gap: 10 enabled, 5 disabled, 10 enabled -> done at edge 25.
        step(0, 1, 8'd20, 1, 0);
        for (int k = 1; k <= 25; k++) begin
            logic e;
            logic [7:0] eq;
            e = !(k > 10 && k <= 15);
            if (k <= 10) eq = 8'(20 - k);
            else if (k <= 15) eq = 8'd10;
            else eq = 8'(25 - k);
            step(0, 0, 8'd0, e, 0);
            check($sformatf("gap_k%0d", k), eq, (k < 25), (k == 25));
        end

        // Auto-reload periodicity N=3 over three periods.
        step(0, 1, 8'd3, 1, 1);
        for (int k = 1; k <= 9; k++) begin
            step(0, 0, 8'd0, 1, 1);
            check($sformatf("arl_k%0d", k), ((k % 3) == 0) ? 8'd3 : 8'(3 - (k % 3)),
                  1, ((k % 3) == 0));
        end
        step(1, 0, 8'd0, 0, 0);
        check("arl_reset", 8'd0, 0, 0);

        // Full-range count: 255 edges, no wrap.
        step(0, 1, 8'd255, 1, 0);
        check("max_load", 8'd255, 1, 0);
        for (int k = 1; k <= 255; k++) begin
            step(0, 0, 8'd0, 1, 0);
            if (k == 1 || k >= 250)
                check($sformatf("max_k%0d", k), 8'(255 - k), (k < 255), (k == 255));
            else if (done !== 1'b0 || q !== 8'(255 - k)) begin
                check($sformatf("max_k%0d", k), 8'(255 - k), 1, 0);
            end
        end
        step(0, 0, 8'd0, 1, 0);
        check("max_nowrap", 8'd0, 0, 0);

        // Re-load mid-run: done only 5 edges after second load.
        step(0, 1, 8'd50, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 8'd0, 1, 0);
            check($sformatf("rl1_k%0d", k), 8'(50 - k), 1, 0);
        end
        step(0, 1, 8'd5, 1, 0);
        check("rl2_load", 8'd5, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 8'd0, 1, 0);
            check($sformatf("rl2_k%0d", k), 8'(5 - k), (k < 5), (k == 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
